// File: rtl/gfx_pkg.sv
// Shared definitions for the background line renderer: colour conversion,
// palette transparency flag, read-pipeline depth and the render FSM states.
package gfx_pkg;

    // Bit of a palette entry that marks the colour as transparent.
    localparam int TRANSP_BIT = 15;

    // Number of stages between issuing a map read and writing the pixel.
    localparam int PIPE_DEPTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } render_state_t;

    // RGB555 down to the RRRGGGBB line-buffer format by keeping the top bits.
    function automatic logic [7:0] rgb555_to_332(input logic [14:0] c);
        return {c[14:12], c[9:7], c[4:3]};
    endfunction

endpackage

// File: rtl/tile_line_renderer_if.sv
// Handshake and memory buses between the renderer, its sequencer and the
// tile-map / glyph / palette / line-buffer memories.
interface tile_line_renderer_if #(
    parameter int PIX_W     = 9,
    parameter int MAP_LOG2  = 6,
    parameter int TILE_LOG2 = 3,
    parameter int BPP       = 2,
    parameter int BANK_LOG2 = 1
) ();
    localparam int GFX_W = 8 + 2*TILE_LOG2 - $clog2(8/BPP);

    logic                    start;
    logic [PIX_W-1:0]        line_y;
    logic [PIX_W-1:0]        scroll_x;
    logic [PIX_W-1:0]        scroll_y;
    logic [14:0]             bg_color;
    logic                    busy;
    logic                    done;
    logic [2*MAP_LOG2-1:0]   map_addr;
    logic [7:0]              map_data;
    logic [GFX_W-1:0]        gfx_addr;
    logic [7:0]              gfx_data;
    logic [8+BPP-1:0]        pal_addr;
    logic [15:0]             pal_data;
    logic                    lb_we;
    logic [BANK_LOG2+10-1:0] lb_addr;
    logic [7:0]              lb_data;

    // Renderer side: owns every address bus and the busy/done handshake.
    modport master (
        input  start, line_y, scroll_x, scroll_y, bg_color,
        input  map_data, gfx_data, pal_data,
        output busy, done, map_addr, gfx_addr, pal_addr,
        output lb_we, lb_addr, lb_data
    );

    // Sequencer and memory side.
    modport slave (
        output start, line_y, scroll_x, scroll_y, bg_color,
        output map_data, gfx_data, pal_data,
        input  busy, done, map_addr, gfx_addr, pal_addr,
        input  lb_we, lb_addr, lb_data
    );

endinterface

// File: rtl/tile_line_renderer_pix_index_sel.sv
// Picks one pixel index out of a packed glyph byte. Pixels are stored
// MSB-first, so pixel 0 of the byte lives in bits [7:8-BPP].
module pix_index_sel #(
    parameter int BPP = 2
) (
    input  logic [7:0]     byte_i,
    input  logic [2:0]     col_i,
    output logic [BPP-1:0] idx_o
);
    localparam int          PPB   = 8 / BPP;
    localparam logic [2:0]  KMASK = 3'(PPB - 1);

    logic [2:0] k;

    // Mask the column down to its position within the byte, then shift it out.
    always_comb begin
        k     = col_i & KMASK;
        idx_o = BPP'(byte_i >> (8 - BPP * (int'(k) + 1)));
    end

endmodule

// File: rtl/tile_line_renderer.sv
// Renders one scrolled tile-map scanline into a banked line buffer, one pixel
// per clock, through map -> glyph -> palette synchronous reads.
module tile_line_renderer
    import gfx_pkg::*;
#(
    parameter int LINE_W    = 400,
    parameter int MAP_LOG2  = 6,
    parameter int TILE_LOG2 = 3,
    parameter int BPP       = 2,
    parameter int BANK_LOG2 = 1,
    parameter int PIX_W     = 9
) (
    input logic                 clk,
    input logic                 rst_n,
    tile_line_renderer_if.master bus
);
    localparam int MT    = MAP_LOG2 + TILE_LOG2;
    localparam int SUB   = $clog2(8 / BPP);
    localparam int GFX_W = 8 + 2*TILE_LOG2 - SUB;
    localparam int XW    = 10;

    render_state_t          state_q;
    logic [1:0]             drain_q;
    logic                   busy_q, done_q;
    logic [XW-1:0]          x0_q, x1_q, x2_q;
    logic                   v0_q, v1_q, v2_q;
    logic [TILE_LOG2-1:0]   ex0_q, ex1_q, ex2_q;
    logic [MT-1:0]          ey_q;
    logic [PIX_W-1:0]       sx_q;
    logic [BANK_LOG2-1:0]   bank_q;
    logic [14:0]            bg_q;
    logic [7:0]             tile2_q;
    logic [2*MAP_LOG2-1:0]  map_addr_q;
    logic                   lb_we_q;
    logic [BANK_LOG2+XW-1:0] lb_addr_q;

    logic [XW-1:0]          x_next_d;
    logic [MT-1:0]          ey_start_d, ex_start_d, ex_next_d;
    logic [8+2*TILE_LOG2-1:0] gfx_full_d;
    logic [2:0]             col_d;
    logic [BPP-1:0]         idx_d;

    // Scrolled coordinates wrap silently at the map edge.
    function automatic logic [MT-1:0] wrapCoord(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
        logic [PIX_W-1:0] s;
        s = a + b;
        return MT'(s);
    endfunction

    // Next-pixel coordinates for the first and for the following map reads.
    always_comb begin
        x_next_d   = x0_q + 10'd1;
        ey_start_d = wrapCoord(bus.line_y, bus.scroll_y);
        ex_start_d = wrapCoord('0, bus.scroll_x);
        ex_next_d  = wrapCoord(PIX_W'(x_next_d), sx_q);
    end

    // Render FSM: latches the request, issues one map read per pixel, drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            drain_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            x0_q       <= '0;
            v0_q       <= 1'b0;
            ex0_q      <= '0;
            ey_q       <= '0;
            sx_q       <= '0;
            bank_q     <= '0;
            bg_q       <= '0;
            map_addr_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q    <= ST_RUN;
                        busy_q     <= 1'b1;
                        v0_q       <= 1'b1;
                        x0_q       <= '0;
                        ex0_q      <= ex_start_d[TILE_LOG2-1:0];
                        ey_q       <= ey_start_d;
                        sx_q       <= bus.scroll_x;
                        bank_q     <= bus.line_y[BANK_LOG2-1:0];
                        bg_q       <= bus.bg_color;
                        map_addr_q <= {ey_start_d[MT-1:TILE_LOG2], ex_start_d[MT-1:TILE_LOG2]};
                    end
                end
                ST_RUN: begin
                    if (x0_q == XW'(LINE_W - 1)) begin
                        state_q    <= ST_DRAIN;
                        v0_q       <= 1'b0;
                        drain_q    <= '0;
                        map_addr_q <= '0;
                    end else begin
                        x0_q       <= x_next_d;
                        ex0_q      <= ex_next_d[TILE_LOG2-1:0];
                        map_addr_q <= {ey_q[MT-1:TILE_LOG2], ex_next_d[MT-1:TILE_LOG2]};
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == 2'(PIPE_DEPTH - 1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Read pipeline: carries valid, x and in-tile column alongside the reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            x1_q      <= '0;
            x2_q      <= '0;
            ex1_q     <= '0;
            ex2_q     <= '0;
            tile2_q   <= '0;
            lb_we_q   <= 1'b0;
            lb_addr_q <= '0;
        end else begin
            v1_q      <= v0_q;
            x1_q      <= x0_q;
            ex1_q     <= ex0_q;
            v2_q      <= v1_q;
            x2_q      <= x1_q;
            ex2_q     <= ex1_q;
            tile2_q   <= bus.map_data;
            lb_we_q   <= v2_q;
            lb_addr_q <= v2_q ? {bank_q, x2_q} : '0;
        end
    end

    assign gfx_full_d = {bus.map_data, ey_q[TILE_LOG2-1:0], ex1_q};
    assign col_d      = 3'(ex2_q);

    pix_index_sel #(.BPP(BPP)) u_pix_index_sel (
        .byte_i (bus.gfx_data),
        .col_i  (col_d),
        .idx_o  (idx_d)
    );

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.map_addr = map_addr_q;
    assign bus.gfx_addr = v1_q ? GFX_W'(gfx_full_d >> SUB) : '0;
    assign bus.pal_addr = v2_q ? {tile2_q, idx_d} : '0;
    assign bus.lb_we    = lb_we_q;
    assign bus.lb_addr  = lb_addr_q;
    assign bus.lb_data  = lb_we_q ? rgb555_to_332(bus.pal_data[TRANSP_BIT] ? bg_q : bus.pal_data[14:0])
                                  : 8'h00;

endmodule

// File: tb/tb_tile_line_renderer.sv
// Directed bench for tile_line_renderer with behavioural BRAM models and an
// independent per-pixel reference for every line-buffer write.
module tb_tile_line_renderer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Free-running pixel clock.
    always #5 clk = ~clk;

    tile_line_renderer_if #(.PIX_W(9), .MAP_LOG2(6), .TILE_LOG2(3), .BPP(2), .BANK_LOG2(1)) bus ();

    tile_line_renderer #(.LINE_W(400), .MAP_LOG2(6), .TILE_LOG2(3), .BPP(2), .BANK_LOG2(1), .PIX_W(9)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0]  mapMem [4096];
    logic [7:0]  gfxMem [4096];
    logic [15:0] palMem [1024];

    // Synchronous memories with one cycle of read latency.
    always @(posedge clk) begin
        bus.map_data <= mapMem[bus.map_addr];
        bus.gfx_data <= gfxMem[bus.gfx_addr];
        bus.pal_data <= palMem[bus.pal_addr];
    end

    logic [7:0] selByte;
    logic [2:0] selCol;
    logic [3:0] idx4;
    logic [0:0] idx1;

    pix_index_sel #(.BPP(4)) sel4 (.byte_i(selByte), .col_i(selCol), .idx_o(idx4));
    pix_index_sel #(.BPP(1)) sel1 (.byte_i(selByte), .col_i(selCol), .idx_o(idx1));

    int checks = 0;
    int errors = 0;
    logic [8:0]  mLineY, mSx, mSy;
    logic [14:0] mBg;
    int expX, writes, firstOff, doneOff;
    bit lineAborted;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference pixel straight from the memory contents and latched request.
    function automatic logic [7:0] modelPixel(input int x);
        int ex, ey, tile, k, idx;
        logic [7:0]  b;
        logic [15:0] pe;
        logic [14:0] c;
        ex   = (x + int'(mSx)) % 512;
        ey   = (int'(mLineY) + int'(mSy)) % 512;
        tile = int'(mapMem[(ey / 8) * 64 + ex / 8]);
        b    = gfxMem[tile * 16 + (ey % 8) * 2 + (ex % 8) / 4];
        k    = ex % 4;
        idx  = (int'(b) >> (6 - 2 * k)) & 3;
        pe   = palMem[tile * 4 + idx];
        c    = pe[15] ? mBg : pe[14:0];
        return {c[14:12], c[9:7], c[4:3]};
    endfunction

    // Pulses start for the current cycle, then scrambles the request inputs.
    task automatic applyStimulus(input logic [8:0] ly, input logic [8:0] sx,
                                 input logic [8:0] sy, input logic [14:0] bg);
        bus.start    = 1'b1;
        bus.line_y   = ly;
        bus.scroll_x = sx;
        bus.scroll_y = sy;
        bus.bg_color = bg;
        mLineY = ly; mSx = sx; mSy = sy; mBg = bg;
        expX = 0; writes = 0; firstOff = -1; doneOff = -1; lineAborted = 1'b0;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.line_y   = ly ^ 9'h1FF;
        bus.scroll_x = sx + 9'd77;
        bus.scroll_y = sy + 9'd33;
        bus.bg_color = ~bg;
    endtask

    // Follows one line cycle by cycle (offset 1 = cycle after start).
    task automatic trackLine(input int testId);
        for (int off = 1; off <= 600; off++) begin
            @(negedge clk);
            if (testId == 1) begin
                if (off == 1)   checkOutput("t1_busy_rise", bus.busy, 1);
                if (off == 3)   checkOutput("t1_no_early_we", bus.lb_we, 0);
                if (off == 4)   checkOutput("t1_first_addr", bus.lb_addr, 32'h400);
                if (off == 4)   checkOutput("t1_transp_bg", bus.lb_data, 32'h2F);
                if (off == 5)   checkOutput("t1_white", bus.lb_data, 32'hFF);
                if (off == 403) checkOutput("t1_busy_last", bus.busy, 1);
            end
            if (testId == 2) begin
                if (off == 1) checkOutput("t2_map0", bus.map_addr, 63);
                if (off == 2) checkOutput("t2_map1", bus.map_addr, 63);
                if (off == 2) checkOutput("t2_gfx0", bus.gfx_addr, 32'h111);
                if (off == 3) checkOutput("t2_map2_wrap", bus.map_addr, 0);
                if (off == 3) checkOutput("t2_gfx1", bus.gfx_addr, 32'h111);
                if (off == 3) checkOutput("t2_pal0", bus.pal_addr, 32'h45);
                if (off == 4) checkOutput("t2_gfx2_wrap", bus.gfx_addr, 32'h220);
                if (off == 4) checkOutput("t2_pal1", bus.pal_addr, 32'h44);
            end
            if (testId == 3) begin
                if (off == 1) checkOutput("t3_b2b_busy", bus.busy, 1);
                if (off == 1) checkOutput("t3_row_wrap", bus.map_addr, 64);
                if (off == 2) checkOutput("t3_gfx", bus.gfx_addr, 32'h5C0);
            end
            if (testId == 5) begin
                if (off == 2) begin
                    bus.start    = 1'b1;
                    bus.line_y   = 9'd1;
                    bus.scroll_x = 9'd200;
                end
                if (off == 3) begin
                    bus.start = 1'b0;
                    checkOutput("t5_busy_kept", bus.busy, 1);
                end
            end
            if (bus.lb_we) begin
                if (writes == 0) firstOff = off;
                checkOutput("lb_addr", bus.lb_addr, {21'd0, mLineY[0], 10'(expX)});
                checkOutput("lb_data", bus.lb_data, modelPixel(expX));
                expX++;
                writes++;
                if (testId == 5 && expX == 201) begin
                    rst_n = 1'b0;
                    #1;
                    checkOutput("rst_we", bus.lb_we, 0);
                    checkOutput("rst_busy", bus.busy, 0);
                    checkOutput("rst_map", bus.map_addr, 0);
                    checkOutput("rst_gfx", bus.gfx_addr, 0);
                    checkOutput("rst_pal", bus.pal_addr, 0);
                    lineAborted = 1'b1;
                    break;
                end
            end
            if (bus.done) begin
                doneOff = off;
                checkOutput("busy_at_done", bus.busy, 0);
                break;
            end
        end
        if (!lineAborted) begin
            checkOutput("done_latency", doneOff, 404);
            checkOutput("write_count", writes, 400);
            checkOutput("first_we_latency", firstOff, 4);
        end
    endtask

    initial begin
        int strayWe, strayDone;
        bus.start = 1'b0; bus.line_y = '0; bus.scroll_x = '0; bus.scroll_y = '0; bus.bg_color = '0;
        for (int i = 0; i < 4096; i++) begin
            mapMem[i] = 8'(i * 7 + 3);
            gfxMem[i] = 8'(i * 29 + 5);
        end
        for (int i = 0; i < 1024; i++) begin
            palMem[i]     = 16'(i * 331 + 17);
            palMem[i][15] = (i % 5 == 0);
        end
        mapMem[63]     = 8'h11;
        mapMem[0]      = 8'h22;
        mapMem[64]     = 8'h5C;
        gfxMem[12'h22A] = 8'h1B;
        gfxMem[12'h111] = 8'hE4;
        palMem[10'h88] = 16'h8000;
        palMem[10'h89] = 16'h7FFF;

        repeat (3) @(negedge clk);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_done", bus.done, 0);
        checkOutput("reset_we", bus.lb_we, 0);
        checkOutput("reset_map", bus.map_addr, 0);
        checkOutput("reset_gfx", bus.gfx_addr, 0);
        checkOutput("reset_pal", bus.pal_addr, 0);
        checkOutput("reset_lbaddr", bus.lb_addr, 0);
        rst_n = 1'b1;

        @(posedge clk); #1;
        applyStimulus(9'd5, 9'd0, 9'd0, 15'h19DD);
        trackLine(1);

        @(posedge clk); #1;
        applyStimulus(9'd0, 9'd510, 9'd0, 15'h0421);
        trackLine(2);

        applyStimulus(9'd20, 9'd0, 9'd500, 15'h7C00);
        trackLine(3);

        @(posedge clk); #1;
        applyStimulus(9'd3, 9'd17, 9'd9, 15'h03E0);
        trackLine(5);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        strayWe = 0;
        strayDone = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.lb_we) strayWe++;
            if (bus.done) strayDone++;
        end
        checkOutput("post_reset_writes", strayWe, 0);
        checkOutput("post_reset_done", strayDone, 0);
        checkOutput("post_reset_busy", bus.busy, 0);

        @(posedge clk); #1;
        applyStimulus(9'd7, 9'd3, 9'd100, 15'h1234);
        trackLine(6);

        selByte = 8'hA5;
        selCol = 3'd0; #1;
        checkOutput("bpp4_even", idx4, 4'hA);
        checkOutput("bpp1_col0", idx1, 1);
        selCol = 3'd1; #1;
        checkOutput("bpp4_odd", idx4, 4'h5);
        checkOutput("bpp1_col1", idx1, 0);
        selCol = 3'd6; #1;
        checkOutput("bpp4_even6", idx4, 4'hA);
        checkOutput("bpp1_col6", idx1, 0);
        selCol = 3'd7; #1;
        checkOutput("bpp4_odd7", idx4, 4'h5);
        checkOutput("bpp1_col7", idx1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
